// File: rtl/ps2_key_source.sv
// ps2_key_source: PS/2 keyboard deframer with F0/E0 prefix folding and a key event FIFO.
// Define PS2KB_TYPEMATIC_FILTER_EN to suppress typematic auto-repeat makes.
module ps2_key_source #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ack,
    input  logic       clr_err,
    output logic [9:0] ps2kb_key,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s, filt, flip, fall;
    logic [FW-1:0] fcnt;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          par, brk_pend;
    logic [WW-1:0] wd;
    logic          good, is_f0, is_e0, rep, push, timeout, err_ev;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp, wp_n, rp_n;
    logic          empty, full, pop, acc, drop;
    logic [8:0]    wr_data, head_n;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign flip  = (clk_s != filt) && (fcnt == FW'(FILTER_LEN - 1));
    assign fall  = flip && filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            fcnt     <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            filt     <= flip ? clk_s : filt;
            fcnt     <= (clk_s == filt || flip) ? '0 : fcnt + FW'(1);
        end
    end

    assign good    = fall && state == STOP && dat_s && ^{sr, par};
    assign is_f0   = sr == 8'hF0;
    assign is_e0   = sr == 8'hE0;
    assign push    = good && !is_f0 && !is_e0 && !rep;
    assign timeout = state != IDLE && !fall && wd == WW'(TIMEOUT_CYC - 1);
    assign err_ev  = timeout || (fall && ((state == IDLE && dat_s) || (state == STOP && !good)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sr       <= '0;
            par      <= 1'b0;
            brk_pend <= 1'b0;
            wd       <= '0;
        end else begin
            wd <= (state == IDLE || fall || timeout) ? '0 : wd + WW'(1);
            if (timeout) begin
                state    <= IDLE;
                brk_pend <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        state   <= dat_s ? IDLE : DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        sr      <= {dat_s, sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= dat_s;
                        state <= STOP;
                    end
                    default: begin
                        state    <= IDLE;
                        brk_pend <= good ? (is_f0 ? 1'b1 : (is_e0 ? brk_pend : 1'b0)) : 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PS2KB_TYPEMATIC_FILTER_EN
    logic [7:0] held;
    logic       held_vld;
    assign rep = held_vld && held == sr && !brk_pend;
    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= '0;
            held_vld <= 1'b0;
        end else if (good && !is_f0 && !is_e0) begin
            held     <= brk_pend ? held : sr;
            held_vld <= brk_pend ? (held_vld && held != sr) : 1'b1;
        end
    end
`else
    assign rep = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign empty   = wp == rp;
    assign full    = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign pop     = rd_ack && !empty;
    assign acc     = push && (!full || pop);
    assign drop    = push && !acc;
    assign wr_data = {brk_pend, sr};
    assign wp_n    = wp + (AW + 1)'(acc);
    assign rp_n    = rp + (AW + 1)'(pop);
    assign head_n  = (acc && rp_n[AW-1:0] == wp[AW-1:0]) ? wr_data : mem[rp_n[AW-1:0]];

    always_ff @(posedge clk) begin
        if (acc) mem[wp[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            ps2kb_key <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wp        <= wp_n;
            rp        <= rp_n;
            ps2kb_key <= (wp_n == rp_n) ? 10'h000 : {1'b1, head_n};
            overflow  <= drop ? 1'b1 : (clr_err ? 1'b0 : overflow);
            frame_err <= err_ev ? 1'b1 : (clr_err ? 1'b0 : frame_err);
        end
    end
endmodule

// File: tb/tb_ps2_key_source.sv
// tb_ps2_key_source: directed PS/2 frame stimulus with hand-computed key events.
module tb_ps2_key_source;
    localparam int HALF = 20;
    localparam int TO   = 2000;

    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd_ack = 1'b0, clr_err = 1'b0;
    logic [9:0] ps2kb_key;
    logic       overflow, frame_err;
    int         errs = 0, checks = 0;
    logic [9:0] exp_q[$];

    ps2_key_source #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_ack(rd_ack),
        .clr_err(clr_err), .ps2kb_key(ps2kb_key), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = b[i];
            idle(HALF);
            ps2_clk = 1'b0;
            idle(HALF);
            ps2_clk = 1'b1;
        end
        idle(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        send_bits({1'b1, ~^d, d, 1'b0}, 11);
    endtask

    task automatic rd;
        rd_ack = 1'b1;
        idle(1);
        rd_ack = 1'b0;
        idle(2);
    endtask

    task automatic clr;
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        idle(2);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(2);
        chk("reset_key", ps2kb_key, 10'h000);
        chk("reset_ovf", {9'd0, overflow}, 10'd0);
        chk("reset_err", {9'd0, frame_err}, 10'd0);
        rd;
        chk("empty_rd", ps2kb_key, 10'h000);

        send(8'h1D);
        chk("t1_key", ps2kb_key, 10'h21D);
        chk("t1_err", {9'd0, frame_err}, 10'd0);

        send(8'hF0);
        send(8'h1D);
        chk("t2_head", ps2kb_key, 10'h21D);
        rd;
        chk("t2_brk", ps2kb_key, 10'h31D);
        rd;
        chk("t2_empty", ps2kb_key, 10'h000);

        for (int i = 1; i <= 9; i++) send(8'(i));
        chk("t3_ovf", {9'd0, overflow}, 10'd1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t3_rd%0d", i), ps2kb_key, 10'h200 | 10'(i));
            rd;
        end
        chk("t3_empty", ps2kb_key, 10'h000);
        clr;
        chk("t3_ovf_clr", {9'd0, overflow}, 10'd0);

        send_bits({1'b1, 1'b0, 8'h1D, 1'b0}, 11);
        chk("t4_err", {9'd0, frame_err}, 10'd1);
        chk("t4_key", ps2kb_key, 10'h000);
        clr;
        chk("t4_clr", {9'd0, frame_err}, 10'd0);

        send_bits({1'b1, 1'b0, 8'h75, 1'b0}, 5);
        idle(TO + 100);
        chk("t5_timeout", {9'd0, frame_err}, 10'd1);
        clr;
        send(8'h75);
        chk("t5_key", ps2kb_key, 10'h275);
        chk("t5_err", {9'd0, frame_err}, 10'd0);
        rd;

`ifdef PS2KB_TYPEMATIC_FILTER_EN
        exp_q = '{10'h21D, 10'h31D, 10'h21D};
`else
        exp_q = '{10'h21D, 10'h21D, 10'h21D, 10'h31D, 10'h21D};
`endif
        send(8'h1D);
        send(8'h1D);
        send(8'h1D);
        send(8'hF0);
        send(8'h1D);
        send(8'h1D);
        foreach (exp_q[i]) begin
            chk($sformatf("t6_ev%0d", i), ps2kb_key, exp_q[i]);
            rd;
        end
        chk("t6_empty", ps2kb_key, 10'h000);

        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        send(8'h2A);
        chk("t7_key", ps2kb_key, 10'h22A);
        chk("t7_err", {9'd0, frame_err}, 10'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ps2_key_source.md
Name: ps2_key_source

Overview:
PS/2 keyboard front end that produces the 10-bit ps2kb_key word the CPU reads at address region 0xD. It samples the raw ps2_clk/ps2_data lines, deframes 11-bit device-to-host frames, folds the F0/E0 prefixes, and buffers key events in a small FIFO. The bus pops one event per CPU read via rd_ack.

Parameters:
FIFO_DEPTH, 8, number of buffered key events; power of two, at least 2.
FILTER_LEN, 4, consecutive equal synchronized samples required before the filtered ps2_clk level changes.
TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
rd_ack  input  1  one-cycle pulse: CPU consumed the current head event
clr_err  input  1  clears the sticky overflow and frame_err flags
ps2kb_key  output  10  {valid, brk, code[7:0]}; all zero when the FIFO is empty
overflow  output  1  sticky: an event was dropped because the FIFO was full
frame_err  output  1  sticky: parity, start, stop or timeout error

Behaviour:
- Reset (synchronous, active-high; clock clk): FIFO empty, ps2kb_key=0, overflow=0, frame_err=0, FSM=IDLE, prefix flags cleared, filtered clk=1, watchdog=0.
- Synchronisation: each raw line passes through a 2-FF synchronizer.
  - The clk filter counts matching samples and flips level after FILTER_LEN agreeing samples.
  - A fall is a filtered 1->0 transition. Data is sampled from synchronized ps2_data on that cycle.
- FSM, advancing only on a fall:
  - IDLE: bit=0 -> DATA with bit count 0; bit=1 -> stay IDLE and set frame_err.
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame is good when stop=1 and data XOR parity has odd weight (odd parity). Then decode and return to IDLE.
  - Bad frame: set frame_err, discard the byte, clear the prefix flags, return to IDLE.
- Watchdog:
  - Counts while FSM != IDLE and resets on every fall.
  - Reaching TIMEOUT_CYC forces IDLE, sets frame_err and clears the prefix flags.
- Decode of a good byte:
  - 0xF0 sets brk_pend, no push.
  - 0xE0 is consumed silently, no push; extended codes map to the same 8-bit code.
  - Any other byte pushes {brk_pend, byte}, then clears brk_pend.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index. Full and empty are decoded from the pointer MSB.
  - Push when full: the event is dropped and overflow is set. FIFO contents are unchanged.
  - rd_ack when empty: ignored, no underflow.
  - Push and rd_ack in the same cycle while full: the pop happens first, then the push succeeds, and overflow is not set.
- ps2kb_key is registered and reflects the new head one cycle after a push or pop: {1, head} when not empty, else 10'h000.
- clr_err clears both sticky flags. An error event in the same cycle wins and the flag stays set.
- Reset mid-frame: the partial frame is lost and the next fall with data=0 starts a fresh frame.

Optional Feature:
Macro PS2KB_TYPEMATIC_FILTER_EN.
- Defined: a make code equal to the most recently pushed make code, with no break of that code since, is suppressed (no push). This removes typematic auto-repeat. A break of that code, or any other make, re-arms the filter. Reset clears the held code.
- Undefined: every make is pushed, including auto-repeat events.

Test Plan:
1. Frame 0x1D (start 0, data LSB first, parity 1, stop 1) -> ps2kb_key=10'h21D one cycle after the stop fall; frame_err=0.
2. Bytes F0,1D then one rd_ack between them and a later read -> events 10'h21D then 10'h31D in order; after the final rd_ack, ps2kb_key=10'h000.
3. Nine make events 0x01..0x09 with FIFO_DEPTH=8 and no reads -> overflow=1; eight reads return 0x01..0x08; 0x09 is lost.
4. Frame 0x1D with wrong parity 0 -> no push, frame_err=1; clr_err pulse -> frame_err=0.
5. Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err=1, FSM IDLE; a following good frame 0x75 yields 10'h275.
6. With PS2KB_TYPEMATIC_FILTER_EN: makes 1D,1D,1D then F0 1D then 1D -> events 21D, 31D, 21D; without the macro -> 21D, 21D, 21D, 31D, 21D.
